// File: rtl/lcd_pkg.sv
// Shared definitions for the scrolling-text LCD marquee: FSM encoding,
// default buffer geometry and HD44780 character codes.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_WAIT
  } lcd_state_t;

  localparam int         LCD_ROW_STRIDE = 64;
  localparam logic [7:0] LCD_FILL_CHAR  = 8'h20;

  localparam logic [7:0] HD_CH_SPACE   = 8'h20;
  localparam logic [7:0] HD_CH_ARROW_R = 8'h7E;
  localparam logic [7:0] HD_CH_ARROW_L = 8'h7F;
  localparam logic [7:0] HD_CH_BLOCK   = 8'hFF;

  // Cycles WAIT allows the controller to raise busy before assuming it missed it.
  localparam logic [3:0] LCD_WAIT_TIMEOUT = 4'd15;

endpackage

// File: rtl/lcd_msg_ram.sv
// Message store for the marquee: MSG_LEN bytes, synchronous write,
// asynchronous read. Writes addressed past the last entry are dropped.
module lcd_msg_ram #(
  parameter int MSG_LEN = 32,
  parameter int AW      = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_dat_o
);

  logic [7:0] mem_q [MSG_LEN];
  logic       wr_ok;

  if ((1 << AW) > MSG_LEN) begin : g_range
    assign wr_ok = (int'(wr_addr_i) < MSG_LEN);
  end else begin : g_full
    assign wr_ok = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (we_i && wr_ok) mem_q[wr_addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_marquee.sv
// Scrolling-text engine that repaints a ROWS x COLS character LCD from a
// rotating message offset. Optional blink frames: LCD_MARQUEE_BLINK_EN.
module lcd_marquee
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter int         ROWS       = 2,
  parameter int         ROW_STRIDE = LCD_ROW_STRIDE,
  parameter int         MSG_LEN    = 32,
  parameter int         TICK_DIV   = 2097152,
  parameter int         ADDR_W     = 7,
  parameter logic [7:0] FILL_CHAR  = LCD_FILL_CHAR,
  localparam int        AW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              CLK12,
  input  logic              reset_n,
  input  logic              run,
  input  logic              dir,
`ifdef LCD_MARQUEE_BLINK_EN
  input  logic              blink,
`endif
  input  logic              msg_we,
  input  logic [AW-1:0]     msg_addr,
  input  logic [7:0]        msg_dat,
  output logic [ADDR_W-1:0] lcd_addr,
  output logic [7:0]        lcd_dat,
  output logic              lcd_we,
  output logic              repaint,
  input  logic              busy,
  output logic              frame_done,
  output logic [AW-1:0]     offset
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  lcd_state_t        state_q;
  logic [TW-1:0]     tick_q;
  logic              tick_wrap;
  logic              pend_q;
  logic [AW-1:0]     offset_q, offset_d;
  logic [AW-1:0]     ptr_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [3:0]        wcnt_q;
  logic              seen_q;
  logic              blank_q, blank_frame;
  logic [ADDR_W-1:0] lcd_addr_q;
  logic [7:0]        lcd_dat_q;
  logic              lcd_we_q, repaint_q, frame_done_q;
  logic [7:0]        rd_dat;

  lcd_msg_ram #(
    .MSG_LEN(MSG_LEN),
    .AW     (AW)
  ) u_ram (
    .clk_i    (CLK12),
    .we_i     (msg_we),
    .wr_addr_i(msg_addr),
    .wr_dat_i (msg_dat),
    .rd_addr_i(ptr_q),
    .rd_dat_o (rd_dat)
  );

`ifdef LCD_MARQUEE_BLINK_EN
  logic phase_q;

  // Phase flips on every frame start while blink is held; text frame first.
  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
    end else if (state_q == ST_IDLE && pend_q) begin
      phase_q <= blink ? ~phase_q : 1'b0;
    end
  end

  assign blank_frame = blink && phase_q;
`else
  assign blank_frame = 1'b0;
`endif

  assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) tick_q <= '0;
    else          tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
  end

  always_comb begin
    offset_d = offset_q;
    if (!dir) offset_d = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
    else      offset_d = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - 1'b1;
  end

  always_ff @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b1;
      offset_q     <= '0;
      ptr_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      wcnt_q       <= '0;
      seen_q       <= 1'b0;
      blank_q      <= 1'b0;
      lcd_addr_q   <= '0;
      lcd_dat_q    <= '0;
      lcd_we_q     <= 1'b0;
      repaint_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      lcd_we_q     <= 1'b0;
      repaint_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (tick_wrap && !pend_q) pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            pend_q     <= 1'b0;
            blank_q    <= blank_frame;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            state_q    <= ST_FILL;
            if (run && !blank_frame) begin
              offset_q <= offset_d;
              ptr_q    <= offset_d;
            end else begin
              ptr_q    <= offset_q;
            end
          end
        end

        // The message index advances by one per cell in row-major order, so a
        // wrapping pointer replaces (offset + r*COLS + c) mod MSG_LEN.
        ST_FILL: begin
          lcd_we_q   <= 1'b1;
          lcd_addr_q <= row_base_q + ADDR_W'(col_q);
          lcd_dat_q  <= blank_q ? FILL_CHAR : rd_dat;
          ptr_q      <= (ptr_q == AW'(MSG_LEN - 1)) ? '0 : ptr_q + 1'b1;
          if (col_q == CW'(COLS - 1)) begin
            col_q      <= '0;
            row_base_q <= row_base_q + ADDR_W'(ROW_STRIDE);
            if (row_q == RW'(ROWS - 1)) state_q <= ST_REQ;
            else                        row_q   <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end

        ST_REQ: begin
          if (!busy) begin
            repaint_q <= 1'b1;
            wcnt_q    <= '0;
            seen_q    <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!seen_q) begin
            if (busy || wcnt_q == LCD_WAIT_TIMEOUT) seen_q <= 1'b1;
            else                                     wcnt_q <= wcnt_q + 1'b1;
          end else if (!busy) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lcd_addr   = lcd_addr_q;
  assign lcd_dat    = lcd_dat_q;
  assign lcd_we     = lcd_we_q;
  assign repaint    = repaint_q;
  assign frame_done = frame_done_q;
  assign offset     = offset_q;

endmodule

// File: tb/tb_lcd_marquee.sv
// Directed bench for lcd_marquee: 2x16 display, 20-byte message, short tick.
module tb_lcd_marquee;

  localparam int COLS = 16, ROWS = 2, STRIDE = 64, MLEN = 20, TDIV = 64, AW_TB = 5;
  localparam int CELLS = ROWS * COLS;

  logic             CLK12 = 1'b0;
  logic             reset_n, run, dir, msg_we, busy, busy_hold;
  logic [AW_TB-1:0] msg_addr;
  logic [7:0]       msg_dat;
  logic [6:0]       lcd_addr;
  logic [7:0]       lcd_dat;
  logic             lcd_we, repaint, frame_done;
  logic [AW_TB-1:0] offset;
`ifdef LCD_MARQUEE_BLINK_EN
  logic             blink;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  int bcnt = 0;
  logic [7:0] msg_m [MLEN];
  logic [7:0] cap_dat [64];
  logic [6:0] cap_addr [64];

  always #5 CLK12 = ~CLK12;

  lcd_marquee #(
    .COLS(COLS), .ROWS(ROWS), .ROW_STRIDE(STRIDE), .MSG_LEN(MLEN),
    .TICK_DIV(TDIV), .ADDR_W(7), .FILL_CHAR(8'h20)
  ) dut (
    .CLK12(CLK12), .reset_n(reset_n), .run(run), .dir(dir),
`ifdef LCD_MARQUEE_BLINK_EN
    .blink(blink),
`endif
    .msg_we(msg_we), .msg_addr(msg_addr), .msg_dat(msg_dat),
    .lcd_addr(lcd_addr), .lcd_dat(lcd_dat), .lcd_we(lcd_we),
    .repaint(repaint), .busy(busy), .frame_done(frame_done), .offset(offset)
  );

  // Controller model: busy for 5 cycles after each repaint, plus a manual hold.
  always @(posedge CLK12) begin
    if (repaint === 1'b1) bcnt <= 5;
    else if (bcnt != 0)   bcnt <= bcnt - 1;
  end
  assign busy = (bcnt != 0) || busy_hold;

  always @(posedge CLK12 or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic grab(output int n, output int off, output logic rep, output logic done);
    int t;
    n = 0; rep = 1'b0; done = 1'b0;
    t = 0;
    while (lcd_we !== 1'b1 && t < 3000) begin @(negedge CLK12); t++; end
    off = int'(offset);
    while (lcd_we === 1'b1 && n < 64) begin
      cap_addr[n] = lcd_addr; cap_dat[n] = lcd_dat; n++;
      @(negedge CLK12);
    end
    t = 0;
    while (repaint !== 1'b1 && t < 300) begin @(negedge CLK12); t++; end
    rep = (repaint === 1'b1);
    t = 0;
    while (frame_done !== 1'b1 && t < 300) begin @(negedge CLK12); t++; end
    done = (frame_done === 1'b1);
    @(negedge CLK12);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; dir = 1'b0; msg_we = 1'b0; busy_hold = 1'b0;
    msg_addr = '0; msg_dat = '0;
`ifdef LCD_MARQUEE_BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(negedge CLK12);
    checks++; if (lcd_we !== 1'b0) begin errors++; $display("FAIL reset lcd_we: got %b want 0", lcd_we); end
    checks++; if (repaint !== 1'b0) begin errors++; $display("FAIL reset repaint: got %b want 0", repaint); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    checks++; if (lcd_addr !== 7'd0) begin errors++; $display("FAIL reset lcd_addr: got %h want 0", lcd_addr); end
    checks++; if (lcd_dat !== 8'd0) begin errors++; $display("FAIL reset lcd_dat: got %h want 0", lcd_dat); end
    checks++; if (offset !== 5'd0) begin errors++; $display("FAIL reset offset: got %0d want 0", offset); end
    for (int i = 0; i < MLEN; i++) begin
      msg_we = 1'b1; msg_addr = AW_TB'(i); msg_dat = 8'h41 + 8'(i); msg_m[i] = 8'h41 + 8'(i);
      @(negedge CLK12);
    end
    msg_we = 1'b0;
  endtask

  task automatic test_first_frame();
    int n, off; logic rep, done;
    reset_n = 1'b1;
    @(negedge CLK12);
    checks++; if (lcd_we !== 1'b0) begin errors++; $display("FAIL latency cycle1 lcd_we: got %b want 0", lcd_we); end
    @(negedge CLK12);
    checks++; if (lcd_we !== 1'b1) begin errors++; $display("FAIL latency cycle2 lcd_we: got %b want 1", lcd_we); end
    grab(n, off, rep, done);
    checks++; if (n !== CELLS) begin errors++; $display("FAIL first_frame we count: got %0d want %0d", n, CELLS); end
    checks++; if (off !== 0) begin errors++; $display("FAIL first_frame offset: got %0d want 0", off); end
    checks++; if (rep !== 1'b1) begin errors++; $display("FAIL first_frame repaint: got %b want 1", rep); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_frame frame_done: got %b want 1", done); end
    for (int i = 0; i < CELLS; i++) begin
      checks++;
      if (cap_addr[i] !== 7'((i / COLS) * STRIDE + (i % COLS))) begin
        errors++; $display("FAIL first_frame addr cell %0d: got %0d want %0d", i, cap_addr[i], (i / COLS) * STRIDE + (i % COLS));
      end
      checks++;
      if (cap_dat[i] !== msg_m[i % MLEN]) begin
        errors++; $display("FAIL first_frame dat cell %0d: got %h want %h", i, cap_dat[i], msg_m[i % MLEN]);
      end
    end
  endtask

  task automatic test_scroll_left();
    int n, off; logic rep, done;
    run = 1'b1; dir = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      grab(n, off, rep, done);
      checks++; if (off !== k) begin errors++; $display("FAIL scroll offset frame %0d: got %0d want %0d", k, off, k); end
      checks++; if (n !== CELLS) begin errors++; $display("FAIL scroll we count frame %0d: got %0d want %0d", k, n, CELLS); end
      checks++; if (cap_dat[0] !== msg_m[k]) begin errors++; $display("FAIL scroll cell0 frame %0d: got %h want %h", k, cap_dat[0], msg_m[k]); end
    end
    checks++; if (cap_dat[0] !== 8'h44) begin errors++; $display("FAIL scroll frame3 cell0: got %h want 44", cap_dat[0]); end
  endtask

  task automatic test_wrap();
    int n, off, e; logic rep, done;
    for (int k = 4; k <= MLEN; k++) begin
      e = k % MLEN;
      grab(n, off, rep, done);
      checks++; if (off !== e) begin errors++; $display("FAIL wrap offset: got %0d want %0d", off, e); end
      checks++;
      if (cap_dat[21] !== msg_m[(e + 21) % MLEN] || cap_addr[21] !== 7'd69) begin
        errors++; $display("FAIL wrap cell r1c5 off %0d: got %h@%0d want %h@69", e, cap_dat[21], cap_addr[21], msg_m[(e + 21) % MLEN]);
      end
    end
  endtask

  task automatic test_dir_right();
    int n, off; logic rep, done;
    dir = 1'b1;
    grab(n, off, rep, done);
    checks++; if (off !== MLEN - 1) begin errors++; $display("FAIL right offset: got %0d want %0d", off, MLEN - 1); end
    checks++; if (cap_dat[0] !== 8'h54) begin errors++; $display("FAIL right cell0: got %h want 54", cap_dat[0]); end
    checks++; if (cap_dat[1] !== 8'h41) begin errors++; $display("FAIL right cell1: got %h want 41", cap_dat[1]); end
    dir = 1'b0;
    grab(n, off, rep, done);
    checks++; if (off !== 0) begin errors++; $display("FAIL left wrap offset: got %0d want 0", off); end
    run = 1'b0;
    grab(n, off, rep, done);
    checks++; if (off !== 0 || done !== 1'b1) begin errors++; $display("FAIL hold offset/done: got %0d/%b want 0/1", off, done); end
  endtask

  task automatic test_busy_hold();
    int n, t, stall, extra;
    t = 0;
    while (cyc % TDIV != 60 && t < 200) begin @(negedge CLK12); t++; end
    busy_hold = 1'b1;
    t = 0;
    while (lcd_we !== 1'b1 && t < 200) begin @(negedge CLK12); t++; end
    n = 0;
    while (lcd_we === 1'b1 && n < 64) begin n++; @(negedge CLK12); end
    checks++; if (n !== CELLS) begin errors++; $display("FAIL busy fill count: got %0d want %0d", n, CELLS); end
    stall = 0;
    repeat (200) begin @(negedge CLK12); if (repaint === 1'b1) stall++; end
    checks++; if (stall !== 0) begin errors++; $display("FAIL busy repaint while busy: got %0d want 0", stall); end
    t = 0;
    while (cyc % TDIV != 2 && t < 100) begin @(negedge CLK12); t++; end
    busy_hold = 1'b0;
    t = 0;
    while (repaint !== 1'b1 && t < 10) begin @(negedge CLK12); t++; end
    checks++; if (repaint !== 1'b1) begin errors++; $display("FAIL busy release repaint: got %b want 1", repaint); end
    t = 0;
    while (frame_done !== 1'b1 && t < 40) begin @(negedge CLK12); t++; end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL busy frame_done: got %b want 1", frame_done); end
    t = 0;
    while (lcd_we !== 1'b1 && t < 5) begin @(negedge CLK12); t++; end
    n = 0;
    while (lcd_we === 1'b1 && n < 64) begin n++; @(negedge CLK12); end
    checks++; if (n !== CELLS) begin errors++; $display("FAIL busy extra frame count: got %0d want %0d", n, CELLS); end
    t = 0;
    while (frame_done !== 1'b1 && t < 60) begin @(negedge CLK12); t++; end
    extra = 0;
    while (cyc % TDIV != TDIV - 1) begin @(negedge CLK12); if (lcd_we === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy queued frames: got %0d writes want 0", extra); end
  endtask

  task automatic test_reset_mid_fill();
    int n, off, t; logic rep, done;
    run = 1'b1;
    t = 0;
    while (lcd_we !== 1'b1 && t < 200) begin @(negedge CLK12); t++; end
    repeat (7) @(negedge CLK12);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (lcd_we !== 1'b0 || lcd_addr !== 7'd0 || lcd_dat !== 8'd0) begin
      errors++; $display("FAIL midfill async outputs: got we=%b addr=%0d dat=%h want 0/0/00", lcd_we, lcd_addr, lcd_dat);
    end
    checks++; if (offset !== 5'd0) begin errors++; $display("FAIL midfill async offset: got %0d want 0", offset); end
    @(negedge CLK12);
    run = 1'b0; msg_we = 1'b1; msg_addr = '0; msg_dat = 8'h7A; msg_m[0] = 8'h7A;
    @(negedge CLK12);
    msg_we = 1'b0; reset_n = 1'b1;
    grab(n, off, rep, done);
    checks++; if (n !== CELLS) begin errors++; $display("FAIL midfill restart count: got %0d want %0d", n, CELLS); end
    checks++; if (off !== 0) begin errors++; $display("FAIL midfill restart offset: got %0d want 0", off); end
    checks++; if (cap_dat[0] !== 8'h7A || cap_dat[20] !== 8'h7A) begin
      errors++; $display("FAIL midfill restart msg0: got %h/%h want 7a/7a", cap_dat[0], cap_dat[20]);
    end
    checks++; if (cap_addr[31] !== 7'd79) begin errors++; $display("FAIL midfill last addr: got %0d want 79", cap_addr[31]); end
  endtask

`ifdef LCD_MARQUEE_BLINK_EN
  task automatic test_blink();
    int n, off, bad; logic rep, done;
    int exp_off [4] = '{1, 1, 2, 2};
    blink = 1'b1; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      grab(n, off, rep, done);
      checks++; if (off !== exp_off[k]) begin errors++; $display("FAIL blink offset frame %0d: got %0d want %0d", k, off, exp_off[k]); end
      bad = 0;
      for (int i = 0; i < CELLS; i++)
        if (cap_dat[i] !== ((k % 2 == 1) ? 8'h20 : msg_m[(exp_off[k] + i) % MLEN])) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL blink frame %0d content: got %0d bad cells want 0", k, bad); end
    end
    blink = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_scroll_left();
    test_wrap();
    test_dir_right();
    test_busy_hold();
    test_reset_mid_fill();
`ifdef LCD_MARQUEE_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_marquee.md
Name: lcd_marquee

Overview:
Parametrised scrolling-text engine that feeds the existing character-LCD controller through its buffer write port (addr/dat/we) and repaint/busy handshake. It holds a MSG_LEN-byte message RAM, loaded by the host. On every scroll tick it rewrites all ROWS x COLS visible cells from a rotating message offset, then requests a repaint. It generalises the fixed two-character scroller to any geometry, message length, scroll rate and direction.

Parameters:
COLS, 16, visible columns per row
ROWS, 2, visible rows (1..4)
ROW_STRIDE, 64, LCD buffer address offset between rows
MSG_LEN, 32, message RAM depth in bytes (>= 1, any value, not only 2^n)
TICK_DIV, 2097152, CLK12 cycles per scroll step (>= ROWS*COLS+8)
ADDR_W, 7, LCD buffer address width
FILL_CHAR, 8'h20, character written when the display is blanked

Ports:
CLK12  in  1  system clock
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = scroll on ticks; 0 = freeze the offset (frames still refresh)
dir  in  1  0 = text moves left (offset+1); 1 = text moves right (offset-1)
msg_we  in  1  message RAM write strobe
msg_addr  in  $clog2(MSG_LEN)  message write address; writes with addr >= MSG_LEN are ignored
msg_dat  in  8  message write data
lcd_addr  out  ADDR_W  LCD buffer address
lcd_dat  out  8  LCD buffer data
lcd_we  out  1  LCD buffer write strobe, one cycle per cell
repaint  out  1  one-cycle repaint request to the LCD controller
busy  in  1  LCD controller busy
frame_done  out  1  one-cycle pulse when a repaint has been accepted
offset  out  $clog2(MSG_LEN)  current scroll offset

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; tick counter=0; offset=0; pend=1, so the first frame is drawn right after reset; lcd_we=0; repaint=0; frame_done=0; lcd_addr=0; lcd_dat=0. Message RAM is not cleared.
- Tick counter counts 0..TICK_DIV-1 and wraps. Wrap sets pend.
- If pend is already set, further ticks are dropped; there is no queueing beyond one.
- FSM states:
  - IDLE: if pend, clear pend. If run=1, step offset modulo MSG_LEN: left takes MSG_LEN-1 to 0; right takes 0 to MSG_LEN-1. If run=0, offset is held. Go to FILL with cell index r=0, c=0.
  - FILL: one cell per cycle, registered outputs. lcd_we=1, lcd_addr=r*ROW_STRIDE+c, lcd_dat=msg[(offset + r*COLS + c) mod MSG_LEN]. The index is computed without a divider, using a running pointer with conditional subtract. Row-major order. Exactly ROWS*COLS consecutive we pulses, then go to REQ.
  - REQ: wait for busy=0, then pulse repaint for one cycle and go to WAIT.
  - WAIT: wait for busy=1 or 16 cycles, whichever comes first. Then wait for busy=0, pulse frame_done, and go to IDLE.
- Latency from pend in IDLE to the first lcd_we is 2 cycles. Frame length is ROWS*COLS cycles plus the handshake.
- Buffer writes are issued regardless of busy; the LCD controller buffer is dual-ported.
- A msg write takes effect on the next cycle. A write during FILL may produce one mixed frame; this is accepted.
- A run/dir change takes effect at the next IDLE step only.
- Reset mid-FILL or mid-handshake aborts immediately. Outputs return to reset values and a partial frame is left in the LCD buffer.

Optional Feature:
LCD_MARQUEE_BLINK_EN
- Defined: adds input blink (1 bit). While blink=1, alternate frames write FILL_CHAR to every cell and the offset is held on those frames. The phase bit resets to 0, meaning the text frame comes first.
- Not defined: no blink port; every frame shows text. Behaviour is identical to the feature-enabled build with blink=0.

Decomposition:
- Package lcd_pkg: FSM state encoding (IDLE/FILL/REQ/WAIT), LCD_ROW_STRIDE default, FILL_CHAR, HD44780 character constants.
- Sub-module lcd_msg_ram: MSG_LEN x 8, one sync write port, one async read port.
- The FSM, tick divider and index pointer stay in lcd_marquee.

Test Plan:
- Reset, TICK_DIV=64, ROWS=2, COLS=16, MSG_LEN=32, msg[i]=8'h41+i, busy model = 1 for 5 cycles after repaint. Expect 32 we pulses: addr 0..15 carry "A".."P", addr 64..79 carry "Q".."`". Then one repaint, then frame_done.
- run=1, dir=0 over 3 ticks: offset goes 0→1→2→3; the first cell of frame 3 is 8'h44. MSG_LEN=20: offset wraps 19→0, and cell r=1,c=5 reads msg[(offset+21) mod 20].
- dir=1 from offset 0: the next offset is MSG_LEN-1, and cell (0,0) = msg[MSG_LEN-1].
- Hold busy=1 for 200 cycles at REQ. Expect no repaint until busy falls, and ticks arriving meanwhile collapse to exactly one extra frame.
- Assert reset_n low mid-FILL at cell 7. Expect outputs to go to zero asynchronously. After release, a full 32-cell frame starts with offset=0.
- With LCD_MARQUEE_BLINK_EN defined and blink=1: frames alternate text/all-8'h20, and the offset advances only on text frames.
